bram0_loader: RTL
=================

# bram0_loader

Upstream feeder for the BRAM accessor stage. Accepts a count-framed stream of DWIDTH-bit rows over a valid/ready handshake and writes them into BRAM0 at consecutive addresses starting at 0. It then pulses start_run_o with run_count_o to the accessor and waits for the accessor's done. All outputs are registered.

## Interface
- CNT_BIT, 8: width of the row counters.
- DWIDTH, 32: BRAM0 row width; four 8-bit numbers per row.
- AWIDTH, 8: BRAM0 address width.
- clk  input  1  clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start_load_i  input  1  one-cycle start request; sampled only in IDLE.
- load_count_i  input  CNT_BIT  number of rows to load; captured with start_load_i.
- s_valid_i  input  1  stream row valid.
- s_data_i  input  DWIDTH  stream row data.
- s_ready_o  output  1  loader can accept a row this cycle.
- addr_b0_o  output  AWIDTH  BRAM0 address.
- ce_b0_o  output  1  BRAM0 chip enable.
- we_b0_o  output  1  BRAM0 write enable.
- d_b0_o  output  DWIDTH  BRAM0 write data.
- start_run_o  output  1  one-cycle start pulse to the accessor.
- run_count_o  output  CNT_BIT  row count for the accessor; held stable from the pulse until the loader returns to IDLE.
- acc_done_i  input  1  accessor done pulse.
- idle_o, load_o, wait_o, done_o  output  1 each  one-hot state flags.

## Operation
- States: IDLE, LOAD, KICK, WAIT, DONE. The flags are one-hot.
- IDLE:
  - start_load_i=1 and load_count_i≠0: capture the count, clear the row counter, go to LOAD.
  - start_load_i=1 and load_count_i=0: go to DONE directly; no writes, no kick.
- LOAD:
  - s_ready_o=1 while accepted < count.
  - Beat = s_valid_i & s_ready_o.
  - Each beat schedules a write of s_data_i at addr = accepted[AWIDTH-1:0] and increments accepted.
  - After the last beat: go to KICK (AUTO_KICK) or DONE (no AUTO_KICK). s_ready_o drops in the cycle after the last beat.
- KICK: start_run_o=1 for exactly one cycle, run_count_o=count, then WAIT.
- WAIT: wait for acc_done_i=1, then DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Ignored inputs:
  - start_load_i outside IDLE.
  - acc_done_i outside WAIT.
  - s_valid_i when s_ready_o=0.
- Address wrap: a count above 2^AWIDTH wraps the address modulo 2^AWIDTH, so later rows overwrite. The counter itself is CNT_BIT wide and never wraps before reaching count.

## Timing
- Reset values: all outputs 0, except idle_o=1; state IDLE; counters 0.
- Write latency: a beat in cycle N gives ce_b0_o=we_b0_o=1 with addr/data in cycle N+1. The BRAM commits at the end of N+1.
- ce_b0_o=we_b0_o=0 in every cycle that follows no beat.
- Back-to-back beats give one write per cycle, for a throughput of 1 row/clk.
- Start-to-ready: start_load_i in cycle N gives load_o=1 and s_ready_o=1 in N+1.
- Last beat in cycle N:
  - Final write in N+1.
  - With AUTO_KICK: KICK in N+1, so start_run_o=1 in N+1, the same cycle as the final write. The accessor's first BRAM0 read is therefore at least one cycle after the write commits.
- acc_done_i in cycle M gives done_o=1 in M+1 and idle_o=1 in M+2.
- Reset mid-operation: asynchronous return to reset values, which drops any pending write. BRAM contents are undefined for the partial load.

## Configuration
- LOADER_AUTO_KICK_EN defined:
  - KICK and WAIT states exist.
  - The loader starts the accessor and waits for acc_done_i before DONE.
- LOADER_AUTO_KICK_EN undefined:
  - LOAD goes to DONE in the cycle after the last beat, so done_o=1 coincides with the final write.
  - start_run_o=0, run_count_o=0, wait_o=0 permanently; acc_done_i is unused.

## Test plan
- Basic load: count=4, rows 0x04030201…0x10 0F0E0D with continuous valid.
  - Writes at addr 0..3 on four consecutive cycles.
  - start_run_o pulses once with run_count_o=4.
  - acc_done_i after 10 cycles gives done_o for one cycle, then idle_o.
- Backpressure gaps: count=3, s_valid_i toggling 1,0,0,1,0,1.
  - Exactly three writes at addr 0,1,2 with data in order.
  - No write strobes in gap cycles.
- Zero count: start_load_i with count=0.
  - done_o=1 in the next cycle.
  - No ce_b0_o and no start_run_o.
- Ignored inputs:
  - start_load_i during LOAD: no effect.
  - acc_done_i during LOAD: no effect.
  - s_valid_i in IDLE: s_ready_o=0, no write.
- Wrap: AWIDTH=2, count=6.
  - Addresses 0,1,2,3,0,1.
  - run_count_o=6.
- Async reset asserted mid-LOAD after 2 beats: outputs take reset values immediately. A following count=2 load writes addr 0,1 cleanly.

Source files
------------

// File: rtl/bram0_loader.sv
// Count-framed stream loader into BRAM0, optionally kicking the accessor afterwards.
// Optional feature macro: LOADER_AUTO_KICK_EN (KICK/WAIT handshake with the accessor).
module bram0_loader #(
  parameter int CNT_BIT = 8,
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_load_i,
  input  logic [CNT_BIT-1:0] load_count_i,
  input  logic               s_valid_i,
  input  logic [DWIDTH-1:0]  s_data_i,
  output logic               s_ready_o,
  output logic [AWIDTH-1:0]  addr_b0_o,
  output logic               ce_b0_o,
  output logic               we_b0_o,
  output logic [DWIDTH-1:0]  d_b0_o,
  output logic               start_run_o,
  output logic [CNT_BIT-1:0] run_count_o,
  input  logic               acc_done_i,
  output logic               idle_o,
  output logic               load_o,
  output logic               wait_o,
  output logic               done_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_BIT-1:0] cnt_q, cnt_d;
  logic [CNT_BIT-1:0] acc_q, acc_d;
  logic               ready_q, ready_d;
  logic               wr_q, wr_d;
  logic [AWIDTH-1:0]  addr_q, addr_d;
  logic [DWIDTH-1:0]  data_q, data_d;
  logic               start_q, start_d;
  logic [CNT_BIT-1:0] run_cnt_q, run_cnt_d;
  logic               idle_q, load_q, wait_q, done_q;
  logic               beat;
  logic [CNT_BIT-1:0] acc_nxt;

  // ready_q is only ever set inside LOAD, so it alone qualifies a beat
  assign beat    = s_valid_i & ready_q;
  assign acc_nxt = acc_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ready_d   = ready_q;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    start_d   = 1'b0;
    run_cnt_d = run_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_load_i) begin
          if (load_count_i != '0) begin
            cnt_d   = load_count_i;
            acc_d   = '0;
            ready_d = 1'b1;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (beat) begin
          wr_d   = 1'b1;
          addr_d = AWIDTH'(acc_q);
          data_d = s_data_i;
          acc_d  = acc_nxt;
          if (acc_nxt == cnt_q) begin
            ready_d = 1'b0;
`ifdef LOADER_AUTO_KICK_EN
            state_d   = S_KICK;
            start_d   = 1'b1;
            run_cnt_d = cnt_q;
`else
            state_d   = S_DONE;
`endif
          end
        end
      end
      S_KICK: state_d = S_WAIT;
      S_WAIT: if (acc_done_i) state_d = S_DONE;
      S_DONE: begin
        state_d   = S_IDLE;
        run_cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      ready_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      start_q   <= 1'b0;
      run_cnt_q <= '0;
      idle_q    <= 1'b1;
      load_q    <= 1'b0;
      wait_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ready_q   <= ready_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      start_q   <= start_d;
      run_cnt_q <= run_cnt_d;
      idle_q    <= (state_d == S_IDLE);
      load_q    <= (state_d == S_LOAD);
      wait_q    <= (state_d == S_WAIT);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign s_ready_o   = ready_q;
  assign addr_b0_o   = addr_q;
  assign ce_b0_o     = wr_q;
  assign we_b0_o     = wr_q;
  assign d_b0_o      = data_q;
  assign start_run_o = start_q;
  assign run_count_o = run_cnt_q;
  assign idle_o      = idle_q;
  assign load_o      = load_q;
  assign wait_o      = wait_q;
  assign done_o      = done_q;

endmodule
